// File: rtl/moving_sum_pkg.sv
// Shared helpers for the multi-channel moving-window summer.
// MEAN_OUT_EN selects the rounded-mean output; round_shift implements that rounding.
package moving_sum_pkg;

  // Channel index width, never narrower than one bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Round-half-up right shift; a shift of zero passes the value through.
  function automatic logic [63:0] round_shift(input logic [63:0] value, input int shift);
    if (shift <= 0) return value;
    return (value + (64'd1 << (shift - 1))) >> shift;
  endfunction

endpackage

// File: rtl/sample_ring.sv
// Per-channel sample history: ring storage, write pointer and fill counter.
// Presents the oldest entry of the addressed channel combinationally.
module sample_ring
  import moving_sum_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int LEN      = 3,
  parameter int CHANNELS = 4,
  localparam int CHW     = ch_width(CHANNELS)
) (
  input  logic             clk,
  input  logic             flush_i,
  input  logic             we_i,
  input  logic [CHW-1:0]   ch_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] old_o,
  output logic             full_o
);

  localparam int WINDOW = 1 << LEN;
  localparam int PW     = (LEN > 0) ? LEN : 1;
  localparam logic [LEN:0] FILL_MAX = (LEN + 1)'(WINDOW);

  logic [WIDTH-1:0] ring_q [CHANNELS][WINDOW];
  logic [PW-1:0]    wptr_q [CHANNELS];
  logic [LEN:0]     fill_q [CHANNELS];

  logic [PW-1:0] wptr_d;
  logic [LEN:0]  fill_d;
  logic          was_full;

  always_comb begin
    was_full = (fill_q[ch_i] == FILL_MAX);
    wptr_d   = (LEN == 0) ? '0 : wptr_q[ch_i] + 1'b1;
    fill_d   = was_full ? FILL_MAX : fill_q[ch_i] + 1'b1;
    // Until the window has filled, the slot about to be overwritten holds no
    // real sample, so it reads as zero regardless of its stale contents.
    old_o    = was_full ? ring_q[ch_i][wptr_q[ch_i]] : '0;
    full_o   = (fill_d == FILL_MAX);
  end

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values; mixing in blocking assignments here would create races.
  always_ff @(posedge clk) begin
    if (flush_i) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wptr_q[c] <= '0;
        fill_q[c] <= '0;
      end
    end else if (we_i) begin
      wptr_q[ch_i] <= wptr_d;
      fill_q[ch_i] <= fill_d;
    end
  end

  // NOTE: the ring itself is deliberately not reset; the fill counter masks
  // every slot not yet written since the last flush, which keeps this a plain
  // memory that can map onto RAM.
  always_ff @(posedge clk) begin
    if (we_i) ring_q[ch_i][wptr_q[ch_i]] <= data_i;
  end

endmodule

// File: rtl/moving_sum_mc.sv
// Time-multiplexed boxcar summer: one shared add/subtract serves all channels.
// Define MEAN_OUT_EN to output the round-half-up window mean instead of the sum.
module moving_sum_mc
  import moving_sum_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int LEN      = 3,
  parameter int CHANNELS = 4,
  localparam int CHW     = ch_width(CHANNELS),
  localparam int SW      = WIDTH + LEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [CHW-1:0]   in_ch,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [CHW-1:0]   out_ch,
  output logic [SW-1:0]    out_sum,
  output logic             out_full
);

  logic flush;
  logic accept;
  logic [WIDTH-1:0] old;
  logic             full_d;

  logic [SW-1:0] sum_q [CHANNELS];
  logic [SW-1:0] sum_d;
  logic [SW-1:0] out_sum_d;

  logic           out_valid_q;
  logic [CHW-1:0] out_ch_q;
  logic [SW-1:0]  out_sum_q;
  logic           out_full_q;

  assign flush  = reset | clear;
  assign accept = in_valid && !flush && (int'(in_ch) < CHANNELS);

  sample_ring #(
    .WIDTH    (WIDTH),
    .LEN      (LEN),
    .CHANNELS (CHANNELS)
  ) u_ring (
    .clk     (clk),
    .flush_i (flush),
    .we_i    (accept),
    .ch_i    (in_ch),
    .data_i  (in_data),
    .old_o   (old),
    .full_o  (full_d)
  );

  // Exact in SW bits: the outgoing sample is always part of the stored sum.
  always_comb begin
    sum_d = sum_q[in_ch] + SW'(in_data) - SW'(old);
`ifdef MEAN_OUT_EN
    out_sum_d = SW'(round_shift(64'(sum_d), LEN));
`else
    out_sum_d = sum_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      for (int c = 0; c < CHANNELS; c++) sum_q[c] <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_sum_q   <= '0;
      out_full_q  <= 1'b0;
    end else if (accept) begin
      sum_q[in_ch] <= sum_d;
      out_valid_q  <= 1'b1;
      out_ch_q     <= in_ch;
      out_sum_q    <= out_sum_d;
      out_full_q   <= full_d;
    end else begin
      out_valid_q  <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_sum   = out_sum_q;
  assign out_full  = out_full_q;

endmodule

// File: tb/tb_moving_sum_mc.sv
// Self-checking bench: directed cases plus random traffic against a queue-based
// window model; a second LEN=0 instance covers the single-sample window.
module tb_moving_sum_mc;

  localparam int WIDTH  = 8;
  localparam int LEN    = 2;
  localparam int NCH    = 3;
  localparam int WINDOW = 4;

  logic       clk = 1'b0;
  logic       reset, clear, in_valid;
  logic [1:0] in_ch;
  logic [7:0] in_data;

  logic       out_valid, out_full;
  logic [1:0] out_ch;
  logic [9:0] out_sum;

  logic       b_valid, b_out_valid, b_out_full;
  logic [0:0] b_ch, b_out_ch;
  logic [7:0] b_out_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  moving_sum_mc #(.WIDTH(WIDTH), .LEN(LEN), .CHANNELS(NCH)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
    .in_ch(in_ch), .in_data(in_data), .out_valid(out_valid),
    .out_ch(out_ch), .out_sum(out_sum), .out_full(out_full)
  );

  moving_sum_mc #(.WIDTH(WIDTH), .LEN(0), .CHANNELS(1)) dut_len0 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(b_valid),
    .in_ch(b_ch), .in_data(in_data), .out_valid(b_out_valid),
    .out_ch(b_out_ch), .out_sum(b_out_sum), .out_full(b_out_full)
  );

  // Reference state: the raw sample history of each channel.
  int unsigned hist [NCH][$];
  logic       exp_valid, exp_full, exp_b_valid, exp_b_full;
  logic [1:0] exp_ch;
  logic [9:0] exp_sum;
  logic [7:0] exp_b_sum;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [1:0] ch, input logic [7:0] d,
                      input logic clr, input logic rst);
    int unsigned s;
    reset = rst; clear = clr; in_valid = v; in_ch = ch; in_data = d;
    b_valid = v; b_ch = ch[0];
    @(posedge clk);
    if (rst || clr) begin
      for (int c = 0; c < NCH; c++) hist[c].delete();
      exp_valid = 0; exp_ch = 0; exp_sum = 0; exp_full = 0;
      exp_b_valid = 0; exp_b_sum = 0; exp_b_full = 0;
    end else begin
      if (v && ch < NCH) begin
        hist[ch].push_back(d);
        if (hist[ch].size() > WINDOW) void'(hist[ch].pop_front());
        s = 0;
        foreach (hist[ch][i]) s += hist[ch][i];
`ifdef MEAN_OUT_EN
        s = (s + 2) / 4;
`endif
        exp_valid = 1; exp_ch = ch; exp_sum = 10'(s);
        exp_full = (hist[ch].size() == WINDOW);
      end else begin
        exp_valid = 0;
      end
      if (v && ch[0] == 1'b0) begin
        exp_b_valid = 1; exp_b_sum = d; exp_b_full = 1;
      end else begin
        exp_b_valid = 0;
      end
    end
    #1;
    check("out_valid", 64'(out_valid), 64'(exp_valid));
    check("out_ch",    64'(out_ch),    64'(exp_ch));
    check("out_sum",   64'(out_sum),   64'(exp_sum));
    check("out_full",  64'(out_full),  64'(exp_full));
    check("len0_valid", 64'(b_out_valid), 64'(exp_b_valid));
    check("len0_ch",    64'(b_out_ch),    64'(0));
    check("len0_sum",   64'(b_out_sum),   64'(exp_b_sum));
    check("len0_full",  64'(b_out_full),  64'(exp_b_full));
  endtask

  initial begin
    reset = 1; clear = 0; in_valid = 0; in_ch = 0; in_data = 0; b_valid = 0; b_ch = 0;
    step(0, 0, 0, 0, 1);
    step(1, 0, 8'd77, 0, 1);

`ifndef MEAN_OUT_EN
    // Ramp on channel 0, window fills on the fourth sample.
    step(1, 0, 10, 0, 0); step(1, 0, 20, 0, 0); step(1, 0, 30, 0, 0);
    step(1, 0, 40, 0, 0);
    check("ramp_sum4", 64'(out_sum), 64'd100);
    check("ramp_full4", 64'(out_full), 64'd1);
    step(1, 0, 50, 0, 0);
    check("ramp_sum5", 64'(out_sum), 64'd140);

    // Interleaved channels stay independent.
    step(0, 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 8'(i), 0, 0);
      step(1, 1, 100, 0, 0);
    end
    check("ilv_ch1_sum", 64'(out_sum), 64'd400);
    check("ilv_ch1_ch", 64'(out_ch), 64'd1);

    // Full-scale samples: sum saturates at 4*255 without wrapping.
    step(0, 0, 0, 1, 0);
    repeat (6) step(1, 0, 255, 0, 0);
    check("max_sum", 64'(out_sum), 64'd1020);
`else
    step(0, 0, 0, 1, 0);
    step(1, 0, 10, 0, 0); step(1, 0, 20, 0, 0); step(1, 0, 30, 0, 0);
    step(1, 0, 41, 0, 0);
    check("mean_round", 64'(out_sum), 64'd25);
    step(0, 0, 0, 1, 0);
    repeat (4) step(1, 0, 255, 0, 0);
    check("mean_max", 64'(out_sum), 64'd255);
`endif

    // Clear, then reset, coinciding with a sample: that sample is dropped.
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 0, 1, 0);
      step(1, 0, 10, 0, 0); step(1, 0, 20, 0, 0); step(1, 0, 30, 0, 0);
      step(1, 0, 99, (k == 0), (k == 1));
      check("flush_drop", 64'(out_valid), 64'd0);
      step(1, 0, 5, 0, 0);
`ifndef MEAN_OUT_EN
      check("flush_restart", 64'(out_sum), 64'd5);
`endif
      check("flush_notfull", 64'(out_full), 64'd0);
    end

    // Out-of-range channel is ignored.
    step(0, 0, 0, 1, 0);
    step(1, 3, 200, 0, 0);
    check("bad_ch_valid", 64'(out_valid), 64'd0);
    step(1, 0, 7, 0, 0);
`ifndef MEAN_OUT_EN
    check("bad_ch_after", 64'(out_sum), 64'd7);
`endif

    // Random traffic, biased toward full-scale data and occasional clears.
    repeat (400) begin
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 255)),
           $urandom_range(0, 59) == 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
